// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, register address width and
// the write-port arbiter state encoding.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    S_NORM  = 1'b0,
    S_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rf_wport_fifo.sv
// LLU result FIFO: DEPTH entries of {rd, data}, power-of-2 depth so the
// pointers wrap naturally. Also answers "is this rd pending in the FIFO?"
// for the ordering check in the arbiter.
module rf_wport_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  push_rd,
  input  logic [XLEN-1:0]                   push_data,
  input  logic                              pop,
  output logic [riscv_pkg::REG_ADDR_W-1:0]  head_rd,
  output logic [XLEN-1:0]                   head_data,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(DEPTH):0]            count,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  query_rd,
  output logic                              query_match
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [riscv_pkg::REG_ADDR_W-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0]                  data_mem [DEPTH];
  logic [AW-1:0]                    wptr;
  logic [AW-1:0]                    rptr;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_rd   = rd_mem[rptr];
  assign head_data = data_mem[rptr];

  // Pointer and occupancy bookkeeping; queued entries are dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage, written at the tail on push.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wptr]   <= push_rd;
      data_mem[wptr] <= push_data;
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    query_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, AW'(AW'(i) - rptr)} < count) && (rd_mem[i] == query_rd))
        query_match = 1'b1;
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter between the WB stage and the
// long-latency unit. WB writes pass straight through; LLU results queue
// and drain in WB-idle cycles. A starvation counter (or a FIFO filling up
// while WB keeps the port) forces a one-cycle pipeline freeze to drain.
// Optional feature macro: RF_WPORT_BYPASS_EN -- an LLU result arriving
// while the FIFO is empty and WB is idle is written directly that cycle.
module rf_wport_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN         = riscv_pkg::XLEN,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  llu_valid,
  output logic                  llu_ready,
  input  logic [REG_ADDR_W-1:0] llu_rd,
  input  logic [XLEN-1:0]       llu_data,
  output logic                  stall_pipe,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  llu_pending,
  output logic [$clog2(DEPTH):0] fifo_count,
  output arb_state_e            arb_state
);

  // LLU handshake: a result transfers when llu_valid && llu_ready in the
  // same cycle; llu_ready depends only on FIFO fullness, never on llu_valid.

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e            state, state_next;
  logic [SW-1:0]         starve_cnt;
  logic                  wb_hit, llu_hit;
  logic                  wb_grant, head_grant, bypass;
  logic                  push, fifo_full, fifo_empty, wb_conflict;
  logic                  starve_inc, become_full;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;

  assign wb_hit  = wb_regwrite && (wb_rd != '0);
  assign llu_hit = llu_valid && (llu_rd != '0);

  // WB owns the port in S_NORM; in S_FORCE the head drains and WB waits.
  assign wb_grant   = (state == S_NORM) && wb_hit;
  assign head_grant = !fifo_empty && ((state == S_FORCE) || !wb_hit);

`ifdef RF_WPORT_BYPASS_EN
  assign bypass = (state == S_NORM) && !wb_hit && fifo_empty && llu_hit;
`else
  assign bypass = 1'b0;
`endif

  // rd==0 results are accepted (llu_ready) but never stored.
  assign push        = llu_hit && !fifo_full && !bypass;
  assign llu_ready   = !fifo_full;
  assign llu_pending = !fifo_empty;
  assign stall_pipe  = (state == S_FORCE);
  assign arb_state   = state;

  assign starve_inc  = !fifo_empty && wb_grant;
  assign become_full = push && wb_grant && (fifo_count == CW'(DEPTH - 1));

  rf_wport_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_rd     (llu_rd),
    .push_data   (llu_data),
    .pop         (head_grant),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .query_rd    (wb_rd),
    .query_match (wb_conflict)
  );

  // Write-port mux; the enable is held low for as long as reset is asserted.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (wb_grant) begin
      rf_we    = 1'b1;
      rf_waddr = wb_rd;
      rf_wdata = wb_data;
    end else if (head_grant) begin
      rf_we    = 1'b1;
      rf_waddr = head_rd;
      rf_wdata = head_data;
    end else if (bypass) begin
      rf_we    = 1'b1;
      rf_waddr = llu_rd;
      rf_wdata = llu_data;
    end
    if (rst) rf_we = 1'b0;
  end

  // Starvation counter: counts cycles WB holds the port over a queued head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (fifo_empty || head_grant) begin
      starve_cnt <= '0;
    end else if (starve_inc && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_NORM;
    else     state <= state_next;
  end

  // FSM next state: force one drain cycle on starvation or on filling up.
  always_comb begin
    state_next = state;
    case (state)
      S_NORM: begin
        if ((starve_inc && (starve_cnt == SW'(STARVE_LIMIT - 1))) || become_full)
          state_next = S_FORCE;
      end
      S_FORCE: state_next = S_NORM;
      default: state_next = S_NORM;
    endcase
  end

  // The upstream scoreboard must never let WB overwrite an rd still queued.
  assert property (@(posedge clk) disable iff (rst) !(wb_hit && wb_conflict))
    else $error("rf_wport_arbiter: WB write to rd %0d pending in LLU FIFO", wb_rd);

endmodule

// File: tb/tb_rf_wport_arbiter.sv
module tb_rf_wport_arbiter;

  localparam int XLEN = 32;
  localparam int EW   = 5 + XLEN;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_regwrite;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            llu_valid;
  logic            llu_ready;
  logic [4:0]      llu_rd;
  logic [XLEN-1:0] llu_data;
  logic            stall_pipe;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            llu_pending;
  logic [2:0]      fifo_count;
  riscv_pkg::arb_state_e arb_state;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  rf_wport_arbiter #(.XLEN(XLEN), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_regwrite (wb_regwrite),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .llu_valid   (llu_valid),
    .llu_ready   (llu_ready),
    .llu_rd      (llu_rd),
    .llu_data    (llu_data),
    .stall_pipe  (stall_pipe),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .llu_pending (llu_pending),
    .fifo_count  (fifo_count),
    .arb_state   (arb_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    @(posedge clk);
    #1;
    wb_regwrite = we;
    wb_rd       = wrd;
    wb_data     = wd;
    llu_valid   = lv;
    llu_rd      = lrd;
    llu_data    = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({rd, data});
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every RF write pops and compares the next expectation.
  task automatic monitor();
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rf_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rf_write: unexpected write rd=%0d data=%h", rf_waddr, rf_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({rf_waddr, rf_wdata} !== e) begin
            errors++;
            $display("FAIL rf_write: got rd=%0d data=%h expected rd=%0d data=%h",
                     rf_waddr, rf_wdata, e[EW-1:XLEN], e[XLEN-1:0]);
          end
        end
      end
    end
  endtask

  task automatic watchdog();
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  endtask

  initial begin
    rst = 1'b1;
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
    llu_valid = 1'b0; llu_rd = '0; llu_data = '0;
    fork
      monitor();
      watchdog();
    join_none

    // Reset state
    repeat (2) settle();
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_stall", 32'(stall_pipe), 0);
    chk("rst_ready", 32'(llu_ready), 1);
    chk("rst_pending", 32'(llu_pending), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: WB only
    drive(1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd5, 32'hA5);
    settle();
    chk("t1_pending", 32'(llu_pending), 0);
    chk("t1_count", 32'(fifo_count), 0);

    // 2: LLU result drains while WB is idle
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
`ifdef RF_WPORT_BYPASS_EN
    expect_wr(5'd7, 32'h1234);
    settle();
    chk("t2_count_c0", 32'(fifo_count), 0);
    idle();
    settle();
    chk("t2_count_c1", 32'(fifo_count), 0);
`else
    settle();
    chk("t2_count_c0", 32'(fifo_count), 0);
    idle();
    expect_wr(5'd7, 32'h1234);
    settle();
    chk("t2_count_c1", 32'(fifo_count), 1);
    chk("t2_pending", 32'(llu_pending), 1);
`endif
    idle();
    settle();
    chk("t2_count_end", 32'(fifo_count), 0);

    // 3: fill the FIFO while WB writes every cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b1, 5'(20 + i), 32'h200 + 32'(i));
      expect_wr(5'(10 + i), 32'h100 + 32'(i));
      settle();
      chk("t3_ready_fill", 32'(llu_ready), 1);
    end
    drive(1'b1, 5'd14, 32'h104, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd20, 32'h200);
    settle();
    chk("t3_stall", 32'(stall_pipe), 1);
    chk("t3_ready_full", 32'(llu_ready), 0);
    chk("t3_count_full", 32'(fifo_count), 4);
    drive(1'b1, 5'd14, 32'h104, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd14, 32'h104);
    settle();
    chk("t3_stall_off", 32'(stall_pipe), 0);
    chk("t3_ready_again", 32'(llu_ready), 1);
    chk("t3_count_after", 32'(fifo_count), 3);
    for (int i = 1; i < 4; i++) begin
      idle();
      expect_wr(5'(20 + i), 32'h200 + 32'(i));
      settle();
    end
    idle();
    settle();
    chk("t3_drained", 32'(fifo_count), 0);

    // 4: starvation guard after 8 WB cycles
    drive(1'b1, 5'd3, 32'h2FF, 1'b1, 5'd9, 32'h99);
    expect_wr(5'd3, 32'h2FF);
    settle();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'd3, 32'h300 + 32'(i), 1'b0, 5'd0, 32'h0);
      expect_wr(5'd3, 32'h300 + 32'(i));
      settle();
      chk("t4_no_stall", 32'(stall_pipe), 0);
    end
    drive(1'b1, 5'd3, 32'h3FF, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd9, 32'h99);
    settle();
    chk("t4_stall", 32'(stall_pipe), 1);
    drive(1'b1, 5'd3, 32'h3FF, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd3, 32'h3FF);
    settle();
    chk("t4_stall_off", 32'(stall_pipe), 0);
    chk("t4_count", 32'(fifo_count), 0);

    // 5: x0 destinations from both sources
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
      settle();
      chk("t5_count", 32'(fifo_count), 0);
      chk("t5_ready", 32'(llu_ready), 1);
    end
    idle();
    settle();
    chk("t5_count_end", 32'(fifo_count), 0);

    // 6: asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd4, 32'h40 + 32'(i), 1'b1, 5'(25 + i), 32'h500 + 32'(i));
      expect_wr(5'd4, 32'h40 + 32'(i));
      settle();
    end
    drive(1'b1, 5'd4, 32'h43, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd4, 32'h43);
    settle();
    chk("t6_count_pre", 32'(fifo_count), 3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rf_we", 32'(rf_we), 0);
    chk("t6_count", 32'(fifo_count), 0);
    chk("t6_stall", 32'(stall_pipe), 0);
    chk("t6_pending", 32'(llu_pending), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t6_post_count", 32'(fifo_count), 0);
      idle();
    end
    settle();

    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
